// File: rtl/sc_et_capture_if.sv
// ---------------------------------------------------------------------------
// sc_et_capture_if
// Result bus of the early-termination capture stage.
//
// Handshake: the master raises out_valid with ones/len/est; these stay
// stable until a cycle where out_valid && out_ready, which is the transfer.
// out_valid never drops without a transfer.
//
// Signals:
//   out_valid  master->slave  result available
//   out_ready  slave->master  consumer accepts result
//   ones       master->slave  CNT_WIDTH+1 bits, number of 1 bits captured
//   len        master->slave  CNT_WIDTH+1 bits, number of valid bits captured
//   est        master->slave  CNT_WIDTH bits, normalised estimate
// ---------------------------------------------------------------------------
interface sc_et_capture_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH:0]   ones;
  logic [CNT_WIDTH:0]   len;
  logic [CNT_WIDTH-1:0] est;

  modport master (
    output out_valid, ones, len, est,
    input  out_ready
  );

  modport slave (
    input  out_valid, ones, len, est,
    output out_ready
  );
endinterface

// File: rtl/sc_et_capture.sv
// ---------------------------------------------------------------------------
// sc_et_capture
// Counts ones in a stochastic bitstream until the upstream early-termination
// stage raises done_in, or until 2^CNT_WIDTH valid bits have been consumed,
// then presents the ones count and the consumed length on a valid/ready bus.
//
// Optional feature (macro SC_ET_NORM_EN): after termination a restoring
// shift-subtract divider runs for CNT_WIDTH+1 cycles and produces
// est = min(floor(ones * 2^CNT_WIDTH / len), 2^CNT_WIDTH-1), with est=0 for
// len==0. Without the macro there is no DIV state and est is tied to 0.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a capture (IDLE, or HOLD on a transfer cycle)
//   bit_in       SC bitstream bit
//   bit_valid    bit_in valid this cycle
//   done_in      early-termination flag, only looked at in RUN
//   busy         high in RUN and DIV
//   state_dbg    current FSM state (IDLE=0, RUN=1, DIV=2, HOLD=3)
//   res          result bus (master side), see sc_et_capture_if
// ---------------------------------------------------------------------------
module sc_et_capture #(
  parameter int CNT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               done_in,
  output logic               busy,
  output logic [1:0]         state_dbg,
  sc_et_capture_if.master    res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DIV  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH:0] LEN_MAX = {1'b1, {CNT_WIDTH{1'b0}}};

  state_t             state;
  logic [CNT_WIDTH:0] ones_cnt;
  logic [CNT_WIDTH:0] len_cnt;
  logic [CNT_WIDTH:0] ones_nxt;
  logic [CNT_WIDTH:0] len_nxt;
  logic               out_valid_q;
  logic               term;

  // Post-increment counts; the terminating bit is included in the result.
  always_comb begin
    len_nxt  = len_cnt + {{CNT_WIDTH{1'b0}}, bit_valid};
    ones_nxt = ones_cnt + {{CNT_WIDTH{1'b0}}, bit_valid & bit_in};
    term     = done_in | (len_nxt == LEN_MAX);
  end

`ifdef SC_ET_NORM_EN
  localparam int DCW = $clog2(CNT_WIDTH + 2);

  // rem holds the running partial remainder of ones*2^CNT_WIDTH; starting it
  // at ones makes the first step decide quotient bit CNT_WIDTH (ones >= len).
  logic [CNT_WIDTH+1:0] rem;
  logic [CNT_WIDTH+1:0] rem_sub;
  logic [CNT_WIDTH-1:0] quo;
  logic [CNT_WIDTH:0]   quo_nxt;
  logic [DCW-1:0]       div_cnt;
  logic [CNT_WIDTH-1:0] est_q;
  logic [CNT_WIDTH-1:0] est_nxt;
  logic                 ge;

  always_comb begin
    ge      = (rem >= {1'b0, len_cnt});
    rem_sub = ge ? (rem - {1'b0, len_cnt}) : rem;
    quo_nxt = {quo, ge};
    // Quotient is at most 2^CNT_WIDTH (ones==len); saturate that case.
    if (len_cnt == '0)
      est_nxt = '0;
    else if (quo_nxt[CNT_WIDTH])
      est_nxt = '1;
    else
      est_nxt = quo_nxt[CNT_WIDTH-1:0];
  end

  assign res.est = est_q;
`else
  assign res.est = '0;
`endif

  assign res.out_valid = out_valid_q;
  assign res.ones      = ones_cnt;
  assign res.len       = len_cnt;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ones_cnt    <= '0;
      len_cnt     <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
`ifdef SC_ET_NORM_EN
      rem         <= '0;
      quo         <= '0;
      div_cnt     <= '0;
      est_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            ones_cnt <= '0;
            len_cnt  <= '0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          ones_cnt <= ones_nxt;
          len_cnt  <= len_nxt;
          if (term) begin
`ifdef SC_ET_NORM_EN
            state   <= DIV;
            rem     <= {1'b0, ones_nxt};
            quo     <= '0;
            div_cnt <= '0;
`else
            state       <= HOLD;
            out_valid_q <= 1'b1;
            busy        <= 1'b0;
`endif
          end
        end

`ifdef SC_ET_NORM_EN
        DIV: begin
          rem     <= rem_sub << 1;
          quo     <= quo_nxt[CNT_WIDTH-1:0];
          div_cnt <= div_cnt + DCW'(1);
          if (div_cnt == DCW'(CNT_WIDTH)) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
            busy        <= 1'b0;
            est_q       <= est_nxt;
          end
        end
`endif

        HOLD: begin
          // out_valid is high throughout HOLD, so out_ready alone is a transfer.
          if (res.out_ready) begin
            out_valid_q <= 1'b0;
            if (start) begin
              state    <= RUN;
              ones_cnt <= '0;
              len_cnt  <= '0;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_et_capture.sv
module tb_sc_et_capture;

  localparam int W  = 4;
  localparam int RW = 3 * W + 2;
`ifdef SC_ET_NORM_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic start, bit_in, bit_valid, done_in;
  logic busy;
  logic [1:0] state_dbg;

  sc_et_capture_if #(.CNT_WIDTH(W)) res_if ();

  sc_et_capture #(.CNT_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .done_in   (done_in),
    .busy      (busy),
    .state_dbg (state_dbg),
    .res       (res_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [RW-1:0] exp_q[$];
  logic stim_bit[$];
  logic stim_vld[$];
  logic stim_done[$];

  // Reference model: walk the stimulus list, stop at the first done or when
  // 2^W valid bits have been consumed, then normalise.
  function automatic void model(output int term, output logic [RW-1:0] exp);
    int o = 0;
    int l = 0;
    int e = 0;
    term = -1;
    for (int i = 0; i < stim_bit.size(); i++) begin
      if (stim_vld[i]) begin
        l = l + 1;
        o = o + int'(stim_bit[i]);
      end
      if (stim_done[i] || l == (1 << W)) begin
        term = i;
        break;
      end
    end
`ifdef SC_ET_NORM_EN
    if (l != 0) begin
      e = (o * (1 << W)) / l;
      if (e > (1 << W) - 1) e = (1 << W) - 1;
    end
`endif
    exp = {(W+1)'(o), (W+1)'(l), W'(e)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_stim();
    stim_bit.delete();
    stim_vld.delete();
    stim_done.delete();
  endtask

  task automatic push_bit(input logic b, input logic v, input logic d);
    stim_bit.push_back(b);
    stim_vld.push_back(v);
    stim_done.push_back(d);
  endtask

  task automatic start_capture();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic play_stream(input int last);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      start     = 1'b0;
      bit_in    = stim_bit[i];
      bit_valid = stim_vld[i];
      done_in   = stim_done[i];
    end
  endtask

  // Waits (bounded) for out_valid; lat=-1 on timeout. busy_gap counts
  // pre-result cycles where busy was low.
  task automatic collect(output int lat, output int busy_gap, output logic [RW-1:0] got);
    lat = -1;
    busy_gap = 0;
    for (int c = 1; c <= LAT + 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bit_in = 1'b0; bit_valid = 1'b0; done_in = 1'b0; start = 1'b0;
      end
      if (res_if.out_valid) begin
        lat = c;
        break;
      end
      if (!busy) busy_gap++;
    end
    got = {res_if.ones, res_if.len, res_if.est};
  endtask

  task automatic accept();
    @(negedge clk);
    res_if.out_ready = 1'b1;
    @(negedge clk);
    res_if.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({res_if.out_valid, busy, res_if.ones, res_if.len, res_if.est} !== '0)
      $display("FAIL reset_outputs got=%h exp=0",
               {res_if.out_valid, busy, res_if.ones, res_if.len, res_if.est});
    else pass_cnt++;
    chk_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_dbg);
    else pass_cnt++;
    rst_n = 1'b1;
    // done_in in IDLE must not do anything
    @(negedge clk);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    chk_cnt++;
    if (state_dbg !== 2'd0 || busy !== 1'b0 || res_if.out_valid !== 1'b0)
      $display("FAIL idle_done_ignored state=%0d busy=%b valid=%b exp=0/0/0",
               state_dbg, busy, res_if.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [9:0] pat;
    int term, lat, gap;
    logic [RW-1:0] e, got;
    pat = 10'b1101001101;
    clear_stim();
    for (int i = 0; i < 10; i++) push_bit(pat[i], 1'b1, i == 9);
    model(term, e);
    exp_q.push_back(e);
    start_capture();
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_run got=%b exp=1", busy);
    else pass_cnt++;
    play_stream(term);
    collect(lat, gap, got);
    chk_cnt++;
    if (lat !== LAT) $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT);
    else pass_cnt++;
    chk_cnt++;
    if (gap !== 0) $display("FAIL basic_busy_gap got=%0d exp=0", gap);
    else pass_cnt++;
    chk_cnt++;
    if (got !== exp_q.pop_front()) $display("FAIL basic_result got=%h exp=%h", got, e);
    else pass_cnt++;
    chk_cnt++;
    if (res_if.ones !== 5'd6 || res_if.len !== 5'd10)
      $display("FAIL basic_counts got=%0d/%0d exp=6/10", res_if.ones, res_if.len);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_hold got=%b exp=0", busy);
    else pass_cnt++;
    accept();
    chk_cnt++;
    if (res_if.out_valid !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL basic_transfer valid=%b state=%0d exp=0/0", res_if.out_valid, state_dbg);
    else pass_cnt++;
  endtask

  // Directed captures sharing one body: cap, gaps, ratio.
  task automatic test_directed(input int kind);
    int term, lat, gap;
    logic [RW-1:0] e, got;
    clear_stim();
    case (kind)
      0: for (int i = 0; i < (1 << W) + 4; i++) push_bit(1'b1, 1'b1, 1'b0);
      1: for (int i = 0; i < 8; i++) push_bit(1'b1, (i % 2) == 0, i == 7);
      default: for (int i = 0; i < 12; i++) push_bit(i == 0 || i == 5 || i == 9, 1'b1, i == 11);
    endcase
    model(term, e);
    exp_q.push_back(e);
    start_capture();
    play_stream(term);
    collect(lat, gap, got);
    chk_cnt++;
    if (lat !== LAT) $display("FAIL directed%0d_latency got=%0d exp=%0d", kind, lat, LAT);
    else pass_cnt++;
    chk_cnt++;
    if (got !== exp_q.pop_front()) $display("FAIL directed%0d_result got=%h exp=%h", kind, got, e);
    else pass_cnt++;
    accept();
  endtask

  task automatic test_backpressure();
    int term, lat, gap;
    logic [RW-1:0] e, got, z;
    clear_stim();
    for (int i = 0; i < 7; i++) push_bit(1'($urandom_range(0, 1)), 1'b1, i == 6);
    model(term, e);
    exp_q.push_back(e);
    start_capture();
    play_stream(term);
    collect(lat, gap, got);
    chk_cnt++;
    if (got !== exp_q.pop_front()) $display("FAIL bp_result got=%h exp=%h", got, e);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_cnt++;
      if ({res_if.ones, res_if.len, res_if.est} !== e || res_if.out_valid !== 1'b1 || busy !== 1'b0)
        $display("FAIL bp_stable%0d got=%h valid=%b busy=%b exp=%h/1/0",
                 k, {res_if.ones, res_if.len, res_if.est}, res_if.out_valid, busy, e);
      else pass_cnt++;
      start = (k == 1 || k == 3);
    end
    @(negedge clk);
    chk_cnt++;
    if (state_dbg !== 2'd3 || res_if.out_valid !== 1'b1)
      $display("FAIL bp_still_hold state=%0d valid=%b exp=3/1", state_dbg, res_if.out_valid);
    else pass_cnt++;
    res_if.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    res_if.out_ready = 1'b0;
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1 || res_if.out_valid !== 1'b0 || state_dbg !== 2'd1)
      $display("FAIL bp_restart busy=%b valid=%b state=%0d exp=1/0/1",
               busy, res_if.out_valid, state_dbg);
    else pass_cnt++;
    // Zero-length capture: done in the first RUN cycle, no valid bit.
    clear_stim();
    push_bit(1'b1, 1'b0, 1'b1);
    model(term, z);
    exp_q.push_back(z);
    bit_in = 1'b1; bit_valid = 1'b0; done_in = 1'b1;
    collect(lat, gap, got);
    chk_cnt++;
    if (lat !== LAT) $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT);
    else pass_cnt++;
    chk_cnt++;
    if (got !== exp_q.pop_front()) $display("FAIL zero_result got=%h exp=%h", got, z);
    else pass_cnt++;
    accept();
  endtask

  task automatic test_random();
    int term, lat, gap, n;
    logic [RW-1:0] e, got;
    for (int it = 0; it < 10; it++) begin
      clear_stim();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++)
        push_bit(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 (i == n - 1) || ($urandom_range(0, 15) == 0));
      model(term, e);
      exp_q.push_back(e);
      start_capture();
      play_stream(term);
      collect(lat, gap, got);
      chk_cnt++;
      if (lat !== LAT) $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, LAT);
      else pass_cnt++;
      chk_cnt++;
      if (got !== exp_q.pop_front()) $display("FAIL rand%0d_result got=%h exp=%h", it, got, e);
      else pass_cnt++;
      accept();
    end
  endtask

  task automatic test_midrun_reset();
    int term, lat, gap;
    logic [RW-1:0] e, got;
    clear_stim();
    for (int i = 0; i < 5; i++) push_bit(1'b1, 1'b1, 1'b0);
    start_capture();
    play_stream(4);
    @(negedge clk);
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({res_if.out_valid, busy, res_if.ones, res_if.len, res_if.est} !== '0 || state_dbg !== 2'd0)
      $display("FAIL midreset_outputs got=%h state=%0d exp=0/0",
               {res_if.out_valid, busy, res_if.ones, res_if.len, res_if.est}, state_dbg);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_stim();
    push_bit(1'b1, 1'b1, 1'b0);
    push_bit(1'b1, 1'b1, 1'b0);
    push_bit(1'b0, 1'b1, 1'b1);
    model(term, e);
    exp_q.push_back(e);
    start_capture();
    play_stream(term);
    collect(lat, gap, got);
    chk_cnt++;
    if (got !== exp_q.pop_front()) $display("FAIL midreset_after got=%h exp=%h", got, e);
    else pass_cnt++;
    accept();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; done_in = 1'b0;
    res_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_directed(0);
    test_directed(1);
    test_directed(2);
    test_backpressure();
    test_random();
    test_midrun_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sc_et_capture.md
Name: sc_et_capture

Overview:
- Downstream consumer of the variable early-termination stage in the stochastic-computing datapath.
- Counts ones in an incoming SC bitstream until the ET stage raises its done flag, or until the maximum stream length is reached.
- Reports the ones count and the consumed stream length through a valid/ready output handshake.
- Optionally normalises the count into a fixed-point probability estimate with a sequential divider.

Parameters:
- CNT_WIDTH, 8, log2 of the maximum stream length; the stream is capped at 2^CNT_WIDTH bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new capture; honoured only in IDLE, or in HOLD on a handshake cycle
- bit_in  input  1  SC bitstream bit
- bit_valid  input  1  bit_in is valid this cycle
- done_in  input  1  early-termination flag from the upstream ET stage
- busy  output  1  high in RUN and DIV
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- ones  output  CNT_WIDTH+1  number of 1 bits captured
- len  output  CNT_WIDTH+1  number of valid bits captured
- est  output  CNT_WIDTH  normalised estimate; zero when SC_ET_NORM_EN is undefined

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - ones, len, est, out_valid, busy all 0.
  - Internal counters and divider registers cleared.
- IDLE:
  - start=1 → RUN next cycle; ones and len counters cleared.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If bit_valid: len_cnt += 1 and ones_cnt += bit_in.
  - Terminate when done_in=1 OR the post-increment len_cnt == 2^CNT_WIDTH.
  - A bit presented with bit_valid=1 in the terminating cycle is counted.
  - done_in is sampled only in RUN; it is ignored in all other states.
  - start is ignored in RUN.
- Termination:
  - Without the feature: go to HOLD. out_valid=1 in the first HOLD cycle, i.e. one cycle after the terminating cycle.
  - With the feature: go to DIV first (see Optional Feature).
- Counter width:
  - Counters are CNT_WIDTH+1 bits; the cap prevents overflow.
  - bit_valid=0 cycles do not advance len.
- HOLD:
  - ones, len and est are stable while out_valid=1.
  - Transfer occurs when out_valid & out_ready.
  - On transfer: out_valid drops next cycle and state → IDLE.
  - If start=1 in the transfer cycle: state → RUN directly, counters cleared.
  - start without out_ready in HOLD is ignored; there is no result drop.
- Zero-length capture: done_in=1 in the first RUN cycle with bit_valid=0 gives ones=0, len=0.
- Reset mid-capture aborts immediately; there is no partial output.

Optional Feature:
- Macro: SC_ET_NORM_EN.
- Defined:
  - Termination enters DIV.
  - DIV runs a restoring shift-subtract divider computing floor(ones·2^CNT_WIDTH / len).
  - Exactly CNT_WIDTH+1 cycles in DIV, then HOLD.
  - Result saturates to 2^CNT_WIDTH−1; this covers ones==len.
  - len==0 gives est=0 with the same latency.
  - busy stays high in DIV; start and done_in are ignored in DIV.
  - Output latency from the terminating cycle = CNT_WIDTH+2 cycles.
- Undefined:
  - No DIV state; est tied to 0.
  - Output latency = 1 cycle.

Test Plan:
- Reset, then start, then 10 valid bits 1,0,1,1,0,0,1,0,1,1 with done_in on the 10th bit → out_valid one cycle later; ones=6, len=10.
- CNT_WIDTH=4, start, constant bit_in=1, done_in=0 → terminates after 16 bits; ones=16, len=16; with SC_ET_NORM_EN, est=15 (saturated).
- Gaps: bit_valid toggling 1,0 across 8 cycles with bit_in=1, done_in on the last cycle (bit_valid=0) → len=4, ones=4.
- Backpressure: out_ready=0 for 5 cycles after out_valid, start pulsed meanwhile → outputs stable, start ignored; out_ready=1 with start=1 → next cycle RUN and busy=1.
- SC_ET_NORM_EN, CNT_WIDTH=8: ones=3, len=12 → est=64 after CNT_WIDTH+2=10 cycles from termination; done_in with len=0 → est=0.
- rst_n asserted mid-RUN after 5 bits → all outputs 0 immediately, state IDLE; a following capture starts from zero counts.
